// File: rtl/johnson_counter_if.sv
// johnson_counter_if
//   Output bundle of the Johnson counter.
//   q       : counter state, straight from the ring flip-flops
//   phase   : binary index 0..2*WIDTH-1 of q
//   wrap    : high while q is the last state of the period
//   illegal : high while q holds a non-Johnson code
//   Modports: master (counter drives), slave (downstream decode/monitor reads).
interface johnson_counter_if #(
    parameter int WIDTH = 3,
    parameter int PW    = $clog2(2*WIDTH)
);
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    phase;
    logic             wrap;
    logic             illegal;

    modport master (output q, output phase, output wrap, output illegal);
    modport slave  (input  q, input  phase, input  wrap, input  illegal);
endinterface

// File: rtl/johnson_counter.sv
// johnson_counter
//   Free-running, self-correcting Johnson (twisted-ring) counter used as a
//   low-glitch phase/sequence generator. Period is 2*WIDTH states; adjacent
//   states differ in one bit.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (0 = reset, q cleared at once)
//   bus : master side of johnson_counter_if (q, phase, wrap, illegal)
//
//   state (WIDTH=3) | meaning
//   000             | phase 0, reset / restart point
//   001, 011, 111   | phases 1..3, ones filling from the LSB
//   110             | phase 4, zeros filling from the LSB
//   100             | phase 5, last state of the period (wrap)
//   010, 101        | illegal, flushed to 000 on the next edge
module johnson_counter #(
    parameter int WIDTH = 3,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_counter_if.master     bus
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [PW-1:0]    phase_c;
    logic             legal_c;

    // Johnson code for phase k: k ones from the LSB for k<=WIDTH,
    // otherwise ones above (k-WIDTH) low zeros.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH) c[i] = (i < k);
            else            c[i] = (i >= k - WIDTH);
        end
        return c;
    endfunction

    // Legality and phase come from one compare against every legal code, so an
    // illegal code reads as phase 0 without extra gating.
    always_comb begin
        phase_c = '0;
        legal_c = 1'b0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            if (q_r == code_of(k)) begin
                legal_c = 1'b1;
                phase_c = PW'(k);
            end
        end
    end

    // Illegal codes jump straight to 000 so recovery is always a single cycle,
    // never a multi-cycle wander through other illegal codes.
    always_comb begin
        q_nxt = '0;
        if (legal_c) q_nxt = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_r <= '0;
        else      q_r <= q_nxt;
    end

    assign bus.q       = q_r;
    assign bus.phase   = phase_c;
    assign bus.wrap    = (q_r == {1'b1, {(WIDTH-1){1'b0}}});
    assign bus.illegal = ~legal_c;

endmodule

// File: tb/tb_johnson_counter.sv
module tb_johnson_counter;

    logic clk;
    logic rst;

    johnson_counter_if #(.WIDTH(3)) jif3 ();
    johnson_counter_if #(.WIDTH(4)) jif4 ();

    johnson_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(jif3.master));
    johnson_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(jif4.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        int ph;
        int wr;
        int il;
    } exp_t;

    exp_t sb3[$];
    exp_t sb4[$];

    int n_err = 0;
    int n_chk = 0;

    // model phase per instance; -1 marks an injected illegal code
    int p3 = 0;
    int p4 = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code_q(input int p, input int w);
        if (p <= w) return (1 << p) - 1;
        return ((1 << w) - 1) ^ ((1 << (p - w)) - 1);
    endfunction

    function automatic exp_t mk_exp(input int p, input int w);
        exp_t e;
        e.q  = code_q(p, w);
        e.ph = p;
        e.wr = (p == 2*w - 1) ? 1 : 0;
        e.il = 0;
        return e;
    endfunction

    function automatic int step(input int p, input int w);
        if (p < 0) return 0;
        return (p + 1) % (2*w);
    endfunction

    task automatic cmp3(input string tag, input exp_t e);
        chk({tag, ".q3"},     int'(jif3.q),       e.q);
        chk({tag, ".phase3"}, int'(jif3.phase),   e.ph);
        chk({tag, ".wrap3"},  int'(jif3.wrap),    e.wr);
        chk({tag, ".ill3"},   int'(jif3.illegal), e.il);
    endtask

    task automatic cmp4(input string tag, input exp_t e);
        chk({tag, ".q4"},     int'(jif4.q),       e.q);
        chk({tag, ".phase4"}, int'(jif4.phase),   e.ph);
        chk({tag, ".wrap4"},  int'(jif4.wrap),    e.wr);
        chk({tag, ".ill4"},   int'(jif4.illegal), e.il);
    endtask

    // one clock edge: expectations are queued when the edge is launched,
    // then popped and compared once the DUT outputs have settled
    task automatic tick(input string tag);
        exp_t e;
        p3 = step(p3, 3);
        p4 = step(p4, 4);
        sb3.push_back(mk_exp(p3, 3));
        sb4.push_back(mk_exp(p4, 4));
        @(posedge clk);
        #1;
        e = sb3.pop_front();
        cmp3(tag, e);
        e = sb4.pop_front();
        cmp4(tag, e);
    endtask

    task automatic force3(input logic [2:0] v, input string tag);
        exp_t e;
        @(negedge clk);
        force dut3.q_r = v;
        #1;
        release dut3.q_r;
        #1;
        e.q = int'(v); e.ph = 0; e.wr = 0; e.il = 1;
        cmp3(tag, e);
        p3 = -1;
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        e = mk_exp(0, 3);

        // held in reset across clock edges
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            cmp3("reset", mk_exp(0, 3));
            cmp4("reset", mk_exp(0, 4));
        end

        @(negedge clk);
        rst = 1'b1;
        p3 = 0;
        p4 = 0;

        // two full WIDTH=3 periods, wrap and phase ride along in each record
        for (int i = 0; i < 12; i++) tick("seq");

        // advance to 111 and reset between edges
        while (p3 != 3) tick("pre_ar");
        #3;
        rst = 1'b0;
        #1;
        cmp3("async_rst", mk_exp(0, 3));
        cmp4("async_rst", mk_exp(0, 4));
        @(negedge clk);
        chk("async_hold.q3", int'(jif3.q), 0);
        rst = 1'b1;
        p3 = 0;
        p4 = 0;
        tick("restart");
        tick("restart2");

        // illegal code recovery
        force3(3'b010, "ill010");
        tick("rec010_a");
        tick("rec010_b");
        force3(3'b101, "ill101");
        tick("rec101_a");
        tick("rec101_b");

        // WIDTH=4 period incl. wrap at 1000, with both rings running
        for (int i = 0; i < 18; i++) tick("w4");

        chk("sb3_empty", sb3.size(), 0);
        chk("sb4_empty", sb4.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
